// File: rtl/bus_initiator.sv
// Bus initiator: queues read/write commands in a small FIFO and replays each
// one on a simple peripheral bus as a fixed four-phase access
// (IDLE -> SETUP -> ACCESS -> HOLD). Read data is captured at the end of
// ACCESS and presented with a one-cycle response pulse during HOLD.
module bus_initiator #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 16,
    parameter int CMD_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdWr,
    input  logic [ADDR_W-1:0] cmdAddr,
    input  logic [DATA_W-1:0] cmdData,
    output logic              rspValid,
    output logic [DATA_W-1:0] rspData,
    output logic [ADDR_W-1:0] busAddr,
    inout  wire  [DATA_W-1:0] busData,
    output logic              busEn,
    output logic              busWr
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // FIFO storage; entry layout is {wr, addr, data}
    logic [ENT_W-1:0] mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;

    logic             push_s;
    logic             pop_s;
    logic [ENT_W-1:0] head_s;
    logic             head_wr_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;

    // Transaction registers and registered bus outputs
    state_e            state_q;
    logic              cmd_wr_q;
    logic [DATA_W-1:0] cmd_data_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic              bus_en_q;
    logic              bus_wr_q;
    logic              drive_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    // Ready comes from a register so a same-cycle pop never opens the FIFO
    assign push_s      = cmdValid & ready_q;
    assign pop_s       = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}});
    assign head_s      = mem_q[rd_ptr_q];
    assign head_wr_s   = head_s[ENT_W-1];
    assign head_addr_s = head_s[DATA_W +: ADDR_W];
    assign head_data_s = head_s[DATA_W-1:0];

    assign cmdReady = ready_q;
    assign rspValid = rsp_valid_q;
    assign rspData  = rsp_data_q;
    assign busAddr  = bus_addr_q;
    assign busEn    = bus_en_q;
    assign busWr    = bus_wr_q;
    assign busData  = drive_q ? cmd_data_q : {DATA_W{1'bz}};

    // FIFO pointer and occupancy next-state; pointers wrap at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO bookkeeping registers; reset empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d < DEPTH_C);
        end
    end

    // FIFO data array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {cmdWr, cmdAddr, cmdData};
        end
    end

    // Transaction FSM with all bus and response outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_wr_q    <= 1'b0;
            cmd_data_q  <= {DATA_W{1'b0}};
            bus_addr_q  <= {ADDR_W{1'b0}};
            bus_en_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bus_en_q    <= 1'b0;
                    bus_wr_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    if (pop_s) begin
                        state_q    <= ST_SETUP;
                        cmd_wr_q   <= head_wr_s;
                        cmd_data_q <= head_data_s;
                        bus_addr_q <= head_addr_s;
                        drive_q    <= head_wr_s;
                    end else begin
                        state_q    <= ST_IDLE;
                        bus_addr_q <= {ADDR_W{1'b0}};
                        drive_q    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state_q  <= ST_ACCESS;
                    bus_en_q <= 1'b1;
                    bus_wr_q <= cmd_wr_q;
                end
                ST_ACCESS: begin
                    state_q  <= ST_HOLD;
                    bus_en_q <= 1'b0;
                    bus_wr_q <= 1'b0;
                    // Peripheral drives the bus during ACCESS of a read
                    if (!cmd_wr_q) begin
                        rsp_data_q  <= busData;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    bus_addr_q  <= {ADDR_W{1'b0}};
                    drive_q     <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    bus_en_q    <= 1'b0;
                    bus_wr_q    <= 1'b0;
                    bus_addr_q  <= {ADDR_W{1'b0}};
                    drive_q     <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
